// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX bridge among NUM_REQ framed requesters.
// Signal (header-only) frames take priority over message frames; completion pulses back per requester.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MESSAGE_SIZE = 512,
  parameter int unsigned HEADER_SIZE  = 32,
  localparam int unsigned IDX_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ-1:0]              req_signal_in,
  input  logic [NUM_REQ*HEADER_SIZE-1:0]  req_header_in,
  input  logic [NUM_REQ*MESSAGE_SIZE-1:0] req_message_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  output logic [NUM_REQ-1:0]              req_done_out,
  input  logic                            bdge_ready_in,
  output logic                            bdge_valid_out,
  output logic [HEADER_SIZE-1:0]          bdge_header_out,
  output logic [MESSAGE_SIZE-1:0]         bdge_message_out,
  output logic                            bdge_signal_out,
  output logic                            busy_out,
  output logic [IDX_W-1:0]                grant_idx_out
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic                    signal_q, signal_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [HEADER_SIZE-1:0]  header_q, header_d;
  logic [MESSAGE_SIZE-1:0] message_q, message_d;

  logic [IDX_W-1:0] idx, sig_win, msg_win, winner;
  logic             found_sig, found_msg, any_valid, accept;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Two independent rotating scans from rr: one over signal frames, one over all frames.
  always_comb begin
    idx       = '0;
    sig_win   = '0;
    msg_win   = '0;
    found_sig = 1'b0;
    found_msg = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx(rr_q, k);
      if (!found_sig && req_valid_in[idx] && req_signal_in[idx]) begin
        found_sig = 1'b1;
        sig_win   = idx;
      end
      if (!found_msg && req_valid_in[idx]) begin
        found_msg = 1'b1;
        msg_win   = idx;
      end
    end
    winner = found_sig ? sig_win : msg_win;
  end

  assign any_valid = |req_valid_in;
  assign accept    = (state_q == StIdle) && bdge_ready_in && any_valid;

  always_comb begin
    req_ready_out = '0;
    if (accept) req_ready_out[winner] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    signal_d  = signal_q;
    done_d    = '0;
    header_d  = header_q;
    message_d = message_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          header_d  = req_header_in[32'(winner) * HEADER_SIZE +: HEADER_SIZE];
          message_d = req_message_in[32'(winner) * MESSAGE_SIZE +: MESSAGE_SIZE];
          signal_d  = req_signal_in[winner];
          grant_d   = winner;
          valid_d   = 1'b1;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        // Bridge dropping ready means it has taken the frame.
        if (!bdge_ready_in) begin
          valid_d = 1'b0;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bdge_ready_in) begin
          done_d[grant_q] = 1'b1;
          if (32'(grant_q) == NUM_REQ - 1) rr_d = '0;
          else rr_d = grant_q + 1'b1;
          signal_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      signal_q  <= 1'b0;
      done_q    <= '0;
      header_q  <= '0;
      message_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      signal_q  <= signal_d;
      done_q    <= done_d;
      header_q  <= header_d;
      message_q <= message_d;
    end
  end

  assign bdge_valid_out   = valid_q;
  assign bdge_signal_out  = signal_q;
  assign bdge_header_out  = header_q;
  assign bdge_message_out = message_q;
  assign req_done_out     = done_q;
  assign grant_idx_out    = grant_q;
  assign busy_out         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: bridge model, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed timing and grant-order expectations.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int HS = 32;
  localparam int MS = 512;
  localparam int IW = 2;
  localparam int TX_LEN = 3;  // cycles the bridge keeps ready low per frame

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_signal = '0;
  logic [N*HS-1:0] req_header;
  logic [N*MS-1:0] req_message;
  logic [N-1:0]    req_ready_out, req_done_out;
  logic            bdge_ready = 1'b0;
  logic            bdge_valid, bdge_signal, busy;
  logic [HS-1:0]   bdge_header;
  logic [MS-1:0]   bdge_message;
  logic [IW-1:0]   grant_idx;
  logic            hold_off = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .MESSAGE_SIZE(MS), .HEADER_SIZE(HS)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_valid_in    (req_valid),
    .req_signal_in   (req_signal),
    .req_header_in   (req_header),
    .req_message_in  (req_message),
    .req_ready_out   (req_ready_out),
    .req_done_out    (req_done_out),
    .bdge_ready_in   (bdge_ready),
    .bdge_valid_out  (bdge_valid),
    .bdge_header_out (bdge_header),
    .bdge_message_out(bdge_message),
    .bdge_signal_out (bdge_signal),
    .busy_out        (busy),
    .grant_idx_out   (grant_idx)
  );

  always #5 clk = ~clk;

  // Bridge: takes a frame on valid&ready, then holds ready low for TX_LEN cycles.
  initial begin : bridge
    int   cnt;
    logic v, r;
    cnt = 0;
    forever begin
      @(negedge clk);
      v = bdge_valid;
      r = bdge_ready;
      @(posedge clk);
      #1;
      if (!rst_n || hold_off) begin
        bdge_ready = 1'b0;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) bdge_ready = 1'b1;
      end else if (v && r) begin
        bdge_ready = 1'b0;
        cnt = TX_LEN;
      end else begin
        bdge_ready = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one frame in flight at a time
  logic          m_active, m_taken, m_vld, m_sig;
  logic [N-1:0]  m_done;
  int            m_grant, m_rr;
  logic [HS-1:0] m_hdr;
  logic [MS-1:0] m_msg;

  logic [N-1:0]  s_req_ready;
  logic          s_busy, s_bvalid, s_bready;
  logic [HS-1:0] s_hdr;
  int            acc_q[$], acc_c[$], done_c[$];
  logic [N-1:0]  done_v[$];
  int            vld_cnt, sig_cnt, rdy_cnt, rdy_rise;
  logic          prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [MS-1:0] act, input logic [MS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] s, input int rr);
    int w;
    bit found;
    w = 0;
    found = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (!found && v[j] && s[j]) begin found = 1; w = j; end
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (!found && v[j]) begin found = 1; w = j; end
    end
    return w;
  endfunction

  function automatic int q_at(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  function automatic logic [N-1:0] dv_at(input int k);
    if (k < done_v.size()) return done_v[k];
    return '1;
  endfunction

  task automatic step();
    logic [N-1:0] er, nd;
    int w;
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_taken = 0; m_vld = 0; m_sig = 0; m_done = '0;
      m_grant = 0; m_rr = 0; m_hdr = '0; m_msg = '0;
    end
    er = '0;
    if (!m_active && bdge_ready && (|req_valid)) er[pick(req_valid, req_signal, m_rr)] = 1'b1;
    chk("req_ready", MS'(req_ready_out), MS'(er));
    chk("req_done", MS'(req_done_out), MS'(m_done));
    chk("bdge_valid", MS'(bdge_valid), MS'(m_vld));
    chk("bdge_signal", MS'(bdge_signal), MS'(m_sig));
    chk("busy", MS'(busy), MS'(m_active));
    chk("grant_idx", MS'(grant_idx), MS'(m_grant));
    chk("bdge_header", MS'(bdge_header), MS'(m_hdr));
    chk("bdge_message", bdge_message, m_msg);

    s_req_ready = req_ready_out;
    s_busy = busy;
    s_bvalid = bdge_valid;
    s_bready = bdge_ready;
    s_hdr = bdge_header;
    for (int k = 0; k < N; k++)
      if (req_ready_out[k] && req_valid[k]) begin acc_q.push_back(k); acc_c.push_back(cyc); end
    if (req_done_out != '0) begin done_c.push_back(cyc); done_v.push_back(req_done_out); end
    if (bdge_valid) vld_cnt++;
    if (bdge_signal) sig_cnt++;
    if (req_ready_out != '0) rdy_cnt++;
    if (bdge_ready && !prev_rdy) rdy_rise = cyc;
    prev_rdy = bdge_ready;

    if (rst_n) begin
      nd = '0;
      if (!m_active) begin
        if (bdge_ready && (|req_valid)) begin
          w = pick(req_valid, req_signal, m_rr);
          m_active = 1; m_taken = 0; m_vld = 1;
          m_sig = req_signal[w];
          m_grant = w;
          m_hdr = req_header[w*HS +: HS];
          m_msg = req_message[w*MS +: MS];
        end
      end else if (!m_taken) begin
        if (!bdge_ready) begin m_taken = 1; m_vld = 0; end
      end else if (bdge_ready) begin
        m_active = 0;
        nd[m_grant] = 1'b1;
        m_rr = (m_grant + 1) % N;
        m_sig = 0;
      end
      m_done = nd;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string name);
    int t = 0;
    while (acc_q.size() < target && t < 40) begin tick(); t++; end
    chk(name, MS'(acc_q.size() >= target), MS'(1));
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (done_c.size() < target && t < 40) begin tick(); t++; end
    chk(name, MS'(done_c.size() >= target), MS'(1));
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_c.delete(); done_c.delete(); done_v.delete();
    vld_cnt = 0; sig_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_header[i*HS +: HS]  = 32'h1000_0000 + 32'(i);
      req_message[i*MS +: MS] = {16{32'hC0DE_0000 + 32'(i)}};
    end
    req_header[0 +: HS] = 32'hA5A5_0001;

    tick();
    tick();
    chk("reset_busy", MS'(s_busy), MS'(0));
    chk("reset_valid", MS'(s_bvalid), MS'(0));
    chk("reset_header", MS'(s_hdr), MS'(0));
    #2;
    rst_n = 1'b1;

    // Single message from requester 0
    clear_logs();
    req_valid = 4'b0001;
    wait_acc(1, "t1_acc_wait");
    req_valid = '0;
    wait_done(1, "t1_done_wait");
    repeat (3) tick();
    chk("t1_acc_idx", MS'(q_at(acc_q, 0)), MS'(0));
    chk("t1_ready_cycles", MS'(rdy_cnt), MS'(1));
    chk("t1_valid_cycles", MS'(vld_cnt), MS'(2));
    chk("t1_header", MS'(s_hdr), MS'(32'hA5A5_0001));
    chk("t1_done_vec", MS'(dv_at(0)), MS'(4'b0001));
    chk("t1_done_count", MS'(done_c.size()), MS'(1));
    chk("t1_done_after_ready", MS'(q_at(done_c, 0) - rdy_rise), MS'(1));
    chk("t1_latency", MS'(q_at(done_c, 0) - q_at(acc_c, 0)), MS'(6));

    // Round-robin with all four message requests held
    do_reset();
    clear_logs();
    req_valid = 4'b1111;
    for (int k = 1; k <= 5; k++) wait_acc(k, "t2_acc_wait");
    req_valid = '0;
    wait_done(5, "t2_done_wait");
    for (int k = 0; k < 5; k++) chk("t2_grant_order", MS'(q_at(acc_q, k)), MS'(k % 4));
    for (int k = 1; k < 5; k++) chk("t2_back_to_back", MS'(q_at(acc_c, k)), MS'(q_at(done_c, k - 1)));

    // Signal priority: req3 signal beats req1 message
    do_reset();
    clear_logs();
    req_valid  = 4'b1010;
    req_signal = 4'b1000;
    wait_acc(1, "t3_acc_wait");
    req_valid[3]  = 1'b0;
    req_signal[3] = 1'b0;
    sig_cnt = 0;
    wait_done(1, "t3_done_wait");
    chk("t3_first_idx", MS'(q_at(acc_q, 0)), MS'(3));
    chk("t3_first_done", MS'(dv_at(0)), MS'(4'b1000));
    chk("t3_signal_cycles", MS'(sig_cnt), MS'(5));
    wait_acc(2, "t3_acc2_wait");
    req_valid = '0;
    sig_cnt = 0;
    chk("t3_second_idx", MS'(q_at(acc_q, 1)), MS'(1));
    wait_done(2, "t3_done2_wait");
    chk("t3_second_done", MS'(dv_at(1)), MS'(4'b0010));
    chk("t3_second_signal", MS'(sig_cnt), MS'(0));

    // Bridge not ready for 10 cycles
    clear_logs();
    hold_off = 1'b1;
    for (int t = 0; t < 5 && s_bready !== 1'b0; t++) tick();
    chk("t4_bridge_low", MS'(s_bready), MS'(0));
    req_valid = 4'b0100;
    repeat (10) begin
      tick();
      chk("t4_no_ready", MS'(s_req_ready), MS'(0));
    end
    #1;
    hold_off = 1'b0;
    wait_acc(1, "t4_acc_wait");
    req_valid = '0;
    chk("t4_acc_idx", MS'(q_at(acc_q, 0)), MS'(2));
    chk("t4_acc_on_ready", MS'(q_at(acc_c, 0)), MS'(rdy_rise));
    wait_done(1, "t4_done_wait");

    // Wrap-around from rr=3
    chk("t5_model_rr", MS'(m_rr), MS'(3));
    clear_logs();
    req_valid = 4'b0101;
    wait_acc(1, "t5_acc_wait");
    req_valid = '0;
    chk("t5_acc_idx", MS'(q_at(acc_q, 0)), MS'(0));
    wait_done(1, "t5_done_wait");

    // Async reset during WAIT_DONE
    clear_logs();
    req_valid = 4'b0100;
    wait_acc(1, "t6_acc_wait");
    req_valid = '0;
    for (int t = 0; t < 10 && !(s_busy && !s_bvalid); t++) tick();
    chk("t6_in_wait_done", MS'(s_busy && !s_bvalid), MS'(1));
    chk("t6_grant_before", MS'(grant_idx), MS'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", MS'(busy), MS'(0));
    chk("t6_valid", MS'(bdge_valid), MS'(0));
    chk("t6_signal", MS'(bdge_signal), MS'(0));
    chk("t6_done", MS'(req_done_out), MS'(0));
    chk("t6_grant", MS'(grant_idx), MS'(0));
    chk("t6_header", MS'(bdge_header), MS'(0));
    chk("t6_message", bdge_message, MS'(0));
    chk("t6_req_ready", MS'(req_ready_out), MS'(0));
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    clear_logs();
    req_valid = 4'b1001;
    wait_acc(1, "t6_acc2_wait");
    req_valid = '0;
    chk("t6_rr_cleared", MS'(q_at(acc_q, 0)), MS'(0));
    wait_done(1, "t6_done_wait");
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmit bridge among `NUM_REQ` upstream producers, such as the message encryptor, the key-exchange FSM and the status/signal generator. The arbiter accepts one framed request at a time and presents it to the bridge's control interface. It holds the header-only "signal" flag for the whole transmission and reports completion back to the originating requester. Signal-class requests take strict priority over full-message requests.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters (≥2).
- `MESSAGE_SIZE`, default 512: message body width in bits.
- `HEADER_SIZE`, default 32: header width in bits.
- `IDX_W` (local): `max(1, $clog2(NUM_REQ))`.

**Ports**
- `clk_in`, input, 1: system clock.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `req_valid_in`, input, `NUM_REQ`: requester i has a frame pending; held until accepted.
- `req_signal_in`, input, `NUM_REQ`: frame i is header-only (signal).
- `req_header_in`, input, `NUM_REQ*HEADER_SIZE`: header i occupies bits `[i*HEADER_SIZE +: HEADER_SIZE]`.
- `req_message_in`, input, `NUM_REQ*MESSAGE_SIZE`: message i, packed the same way.
- `req_ready_out`, output, `NUM_REQ`: one-hot, combinational accept; transfer occurs when `valid[i] & ready[i]` at a clock edge.
- `req_done_out`, output, `NUM_REQ`: one-cycle pulse when frame i has fully left the bridge.
- `bdge_ready_in`, input, 1: the bridge's ready output.
- `bdge_valid_out`, output, 1: drives the bridge's `ctrl_valid_in`.
- `bdge_header_out`, output, `HEADER_SIZE`: latched header.
- `bdge_message_out`, output, `MESSAGE_SIZE`: latched message.
- `bdge_signal_out`, output, 1: drives the bridge's `sending_signal`.
- `busy_out`, output, 1: high whenever the state is not IDLE.
- `grant_idx_out`, output, `IDX_W`: index of the current or last granted requester.

## Operation

- **States:** IDLE, LAUNCH, WAIT_DONE. A round-robin pointer `rr` (`IDX_W` bits) holds the highest-priority index.
- **Winner selection:** evaluated in IDLE only.
  - If any `req_valid_in[i] & req_signal_in[i]` is set, the winner is the first such i scanning from `rr` upward, wrapping at `NUM_REQ`.
  - Otherwise the winner is the first valid i from `rr` upward, wrapping.
  - Message requests may starve under continuous signal traffic; this is accepted.
- **IDLE:**
  - `req_ready_out` = onehot(winner) when `bdge_ready_in=1` and any request is valid; otherwise 0.
  - On accept: latch header, message and signal into the `bdge_*_out` registers, set `grant_idx_out`=winner, set `bdge_valid_out`=1, and go to LAUNCH.
- **LAUNCH:**
  - `bdge_valid_out` stays 1 while `bdge_ready_in=1`.
  - At the first edge that samples `bdge_ready_in=0`, set `bdge_valid_out`=0 and go to WAIT_DONE.
- **WAIT_DONE:**
  - At the first edge that samples `bdge_ready_in=1`:
    - `req_done_out[grant]` goes to 1 for one cycle.
    - `rr` becomes `(grant+1) mod NUM_REQ`.
    - `bdge_signal_out` goes to 0.
    - The state returns to IDLE.
- **Held outputs:**
  - `bdge_signal_out` holds its latched value from accept until the done edge. The bridge samples it at the end of the header.
  - Header and message outputs hold until the next accept.

## Timing

- **Reset:** `rst_n_in` low immediately forces the following, regardless of state, including mid-transmission:
  - state=IDLE and `rr`=0;
  - `bdge_valid_out`, `bdge_signal_out`, `req_done_out`, `grant_idx_out`, `bdge_header_out` and `bdge_message_out` all 0;
  - `busy_out`=0;
  - `req_ready_out`=0, because the bridge is not ready while it is in reset.
- **Accept to bridge:** `bdge_valid_out` rises one cycle after the accept edge (edge E0).
  - A bridge accepting at E1 drops ready after E1.
  - The arbiter samples that at E2 and drops valid, so valid is high for exactly 2 cycles against the codebase bridge.
- **Done:** `req_done_out` rises one cycle after the bridge's ready returns high.
- **Back-to-back:** in the IDLE cycle that carries the done pulse, a new accept is permitted, and it uses the updated `rr`.
- **No accept** occurs while `bdge_ready_in=0`, even when the state is IDLE.
- **Simultaneous valids:** exactly one `req_ready_out` bit is high; the rest see 0 and must keep holding.
- **Zero-latency accept:** the only combinational input-to-output path is `req_valid_in`/`req_signal_in`/`bdge_ready_in` to `req_ready_out`.

## Test plan

- **Async reset in WAIT_DONE:** drop `rst_n_in` mid-WAIT_DONE (drive `rst_n_in` asynchronously, off the clock edge) → all outputs are 0 before the next edge; after release, `rr`=0.
- **Single message:** req0 valid with header 0xA5A5_0001 against a bridge model → `req_ready_out`=0001 for 1 cycle; `bdge_valid_out` high 2 cycles; `bdge_header_out`=0xA5A5_0001; exactly one `req_done_out[0]` pulse one cycle after ready returns.
- **Round-robin:** all 4 message requests held valid continuously → grant order 0, 1, 2, 3, 0; each done pulse is followed by the next accept in the same IDLE cycle.
- **Signal priority:** req1 message and req3 signal valid together, `rr`=0 → req3 granted first with `bdge_signal_out`=1 held until `req_done_out[3]`; then req1 is granted with `bdge_signal_out`=0.
- **Bridge not ready:** `bdge_ready_in` held 0 for 10 cycles with req2 valid → `req_ready_out`=0 throughout; the accept happens on the first cycle `bdge_ready_in`=1.
- **Wrap-around:** with `rr`=3 and requests 0 and 2 valid (messages) → req0 is granted.
